// File: rtl/dsp_branch_ctrl_pkg.sv
// Shared flow-control definitions for the DSP core.
// Decode and the branch controller both use this package.
package dsp_branch_ctrl_pkg;

   localparam int FLOW_MODE_LEN = 3;

   typedef enum logic [FLOW_MODE_LEN-1:0] {
      FLOW_NONE = 3'd0,
      FLOW_JMP  = 3'd1,
      FLOW_BEZ  = 3'd2,
      FLOW_BNEZ = 3'd3,
      FLOW_BEQ  = 3'd4,
      FLOW_CALL = 3'd5,
      FLOW_RET  = 3'd6,
      FLOW_RSVD = 3'd7
   } flow_mode_e;

   // BEQ relies on the ALU producing a-b, so it shares the zero test with BEZ.
   function automatic logic cond_taken(input flow_mode_e mode, input logic zero,
                                       input logic stack_empty);
      logic taken;
      taken = 1'b0;
      case (mode)
         FLOW_JMP, FLOW_CALL: taken = 1'b1;
         FLOW_BEZ, FLOW_BEQ:  taken = zero;
         FLOW_BNEZ:           taken = ~zero;
         FLOW_RET:            taken = ~stack_empty;
         default:             taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/dsp_ret_stack.sv
// Circular return-address stack; a push into a full stack overwrites
// the oldest entry and the occupancy count saturates at STACK_DEPTH.
module dsp_ret_stack
   import dsp_branch_ctrl_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int STACK_DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             push,
   input  logic                             pop,
   input  logic [ADDR_W-1:0]                din,
   output logic [ADDR_W-1:0]                dout,
   output logic [$clog2(STACK_DEPTH):0]     count,
   output logic                             full,
   output logic                             empty
);

   localparam int PTR_W = $clog2(STACK_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] r_mem [STACK_DEPTH];
   logic [PTR_W-1:0]  r_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [PTR_W-1:0]  w_top_ptr;

   always_comb begin
      w_top_ptr = r_ptr - PTR_W'(1);
      dout      = r_mem[w_top_ptr];
      count     = r_count;
      full      = (r_count == CNT_W'(STACK_DEPTH));
      empty     = (r_count == '0);
   end

   // r_ptr is the next free slot; when full it also points at the oldest entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_ptr   <= '0;
         r_count <= '0;
      end else if (push) begin
         r_mem[r_ptr] <= din;
         r_ptr        <= r_ptr + PTR_W'(1);
         if (!full) begin
            r_count <= r_count + CNT_W'(1);
         end
      end else if (pop && !empty) begin
         r_ptr   <= w_top_ptr;
         r_count <= r_count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/dsp_branch_ctrl.sv
// Registered branch controller: resolves flow codes from execute, issues a
// one-cycle redirect to fetch, flushes younger instructions, manages CALL/RET.
module dsp_branch_ctrl
   import dsp_branch_ctrl_pkg::*;
#(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 16,
   parameter int STACK_DEPTH  = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          valid,
   input  logic [FLOW_MODE_LEN-1:0]      flow_mode,
   input  logic [ADDR_W-1:0]             address,
   input  logic [ADDR_W-1:0]             return_addr,
   input  logic [DATA_W-1:0]             alu_result,
   input  logic                          err_clr,
   output logic [ADDR_W-1:0]             jump_addr,
   output logic                          jump_flag,
   output logic                          flush,
   output logic [$clog2(STACK_DEPTH):0]  stack_count,
   output logic                          stack_overflow,
   output logic                          stack_underflow
);

   localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

   flow_mode_e        w_mode;
   logic              w_flush;
   logic              w_accept;
   logic              w_taken;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   logic              w_ovf_set;
   logic              w_unf_set;
   logic [ADDR_W-1:0] w_top;
   logic [ADDR_W-1:0] w_target;

   logic [FC_W-1:0]   r_flush_cnt;
   logic              r_jump_flag;
   logic [ADDR_W-1:0] r_jump_addr;
   logic              r_ovf;
   logic              r_unf;

   dsp_ret_stack #(
      .ADDR_W      (ADDR_W),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_ret_stack (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .pop   (w_pop),
      .din   (return_addr),
      .dout  (w_top),
      .count (stack_count),
      .full  (w_full),
      .empty (w_empty)
   );

   always_comb begin
      w_mode    = flow_mode_e'(flow_mode);
      w_flush   = (r_flush_cnt != '0);
      w_accept  = valid & ~w_flush;
      w_taken   = w_accept & cond_taken(w_mode, (alu_result == '0), w_empty);
      w_push    = w_accept & (w_mode == FLOW_CALL);
      w_pop     = w_accept & (w_mode == FLOW_RET) & ~w_empty;
      w_ovf_set = w_push & w_full;
      w_unf_set = w_accept & (w_mode == FLOW_RET) & w_empty;
      w_target  = (w_mode == FLOW_RET) ? w_top : address;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_flush_cnt <= '0;
         r_jump_flag <= 1'b0;
         r_jump_addr <= '0;
         r_ovf       <= 1'b0;
         r_unf       <= 1'b0;
      end else begin
         r_jump_flag <= w_taken;
         if (w_taken) begin
            r_jump_addr <= w_target;
            r_flush_cnt <= FC_W'(FLUSH_CYCLES);
         end else if (w_flush) begin
            r_flush_cnt <= r_flush_cnt - FC_W'(1);
         end
         // A set event in the same cycle as err_clr keeps the flag set.
         if (w_ovf_set)    r_ovf <= 1'b1;
         else if (err_clr) r_ovf <= 1'b0;
         if (w_unf_set)    r_unf <= 1'b1;
         else if (err_clr) r_unf <= 1'b0;
      end
   end

   assign jump_addr       = r_jump_addr;
   assign jump_flag       = r_jump_flag;
   assign flush           = w_flush;
   assign stack_overflow  = r_ovf;
   assign stack_underflow = r_unf;

endmodule

// File: tb/tb_dsp_branch_ctrl.sv
// Scoreboard bench for dsp_branch_ctrl: directed scenarios plus random traffic
// against a queue-based behavioural model.
module tb_dsp_branch_ctrl;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 4;
   localparam int FLUSH  = 2;

   logic              clk;
   logic              rst;
   logic              valid;
   logic [2:0]        flow_mode;
   logic [ADDR_W-1:0] address;
   logic [ADDR_W-1:0] return_addr;
   logic [DATA_W-1:0] alu_result;
   logic              err_clr;
   logic [ADDR_W-1:0] jump_addr;
   logic              jump_flag;
   logic              flush;
   logic [2:0]        stack_count;
   logic              stack_overflow;
   logic              stack_underflow;

   dsp_branch_ctrl #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .STACK_DEPTH  (DEPTH),
      .FLUSH_CYCLES (FLUSH)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .valid           (valid),
      .flow_mode       (flow_mode),
      .address         (address),
      .return_addr     (return_addr),
      .alu_result      (alu_result),
      .err_clr         (err_clr),
      .jump_addr       (jump_addr),
      .jump_flag       (jump_flag),
      .flush           (flush),
      .stack_count     (stack_count),
      .stack_overflow  (stack_overflow),
      .stack_underflow (stack_underflow)
   );

   typedef struct {
      logic        jf;
      logic [15:0] ja;
      logic        fl;
      int          cnt;
      logic        ovf;
      logic        unf;
   } exp_t;

   exp_t        sb[$];
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Behavioural model state: the visible outputs after the last edge.
   logic [15:0] m_stack[$];
   int          m_flush;
   logic        m_jf;
   logic [15:0] m_ja;
   logic        m_ovf;
   logic        m_unf;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_stack.delete();
      m_flush = 0;
      m_jf    = 1'b0;
      m_ja    = '0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
   endtask

   task automatic issue(input logic v, input int m, input logic [15:0] a,
                        input logic [15:0] ra, input logic [15:0] alu, input logic clr);
      logic        acc;
      logic        tk;
      logic        set_o;
      logic        set_u;
      logic [15:0] tgt;
      exp_t        e;
      @(negedge clk);
      valid       = v;
      flow_mode   = 3'(m);
      address     = a;
      return_addr = ra;
      alu_result  = alu;
      err_clr     = clr;
      acc   = v && (m_flush == 0);
      tk    = 1'b0;
      set_o = 1'b0;
      set_u = 1'b0;
      tgt   = a;
      if (acc) begin
         case (m)
            1, 5:    tk = 1'b1;
            2, 4:    tk = (alu == 16'h0);
            3:       tk = (alu != 16'h0);
            6:       tk = (m_stack.size() != 0);
            default: tk = 1'b0;
         endcase
         if (m == 5) begin
            if (m_stack.size() == DEPTH) set_o = 1'b1;
            m_stack.push_back(ra);
            if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
         end
         if (m == 6) begin
            if (m_stack.size() > 0) tgt = m_stack.pop_back();
            else set_u = 1'b1;
         end
      end
      m_jf = tk;
      if (tk) m_ja = tgt;
      m_flush = tk ? FLUSH : ((m_flush > 0) ? m_flush - 1 : 0);
      m_ovf = set_o ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_unf = set_u ? 1'b1 : (clr ? 1'b0 : m_unf);
      e.jf  = m_jf;
      e.ja  = m_ja;
      e.fl  = (m_flush != 0);
      e.cnt = m_stack.size();
      e.ovf = m_ovf;
      e.unf = m_unf;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) issue(1'b0, 0, 16'h0, 16'h0, 16'h1, 1'b0);
   endtask

   // Monitor: the DUT presents a result every cycle after an issued instruction.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("jump_flag", 32'(jump_flag), 32'(e.jf));
            chk("jump_addr", 32'(jump_addr), 32'(e.ja));
            chk("flush", 32'(flush), 32'(e.fl));
            chk("stack_count", 32'(stack_count), 32'(e.cnt));
            chk("stack_overflow", 32'(stack_overflow), 32'(e.ovf));
            chk("stack_underflow", 32'(stack_underflow), 32'(e.unf));
         end
      end
   end

   initial begin
      rst = 1'b1;
      valid = 1'b0; flow_mode = '0; address = '0; return_addr = '0;
      alu_result = '0; err_clr = 1'b0;
      model_reset();
      #1;
      chk("rst_jump_addr", 32'(jump_addr), 0);
      chk("rst_jump_flag", 32'(jump_flag), 0);
      chk("rst_flush", 32'(flush), 0);
      chk("rst_stack_count", 32'(stack_count), 0);
      chk("rst_overflow", 32'(stack_overflow), 0);
      chk("rst_underflow", 32'(stack_underflow), 0);
      #11 rst = 1'b0;
      idle(2);

      // JMP, then two valid instructions squashed by the flush window.
      issue(1'b1, 1, 16'h0040, 16'h0, 16'h5, 1'b0);
      issue(1'b1, 1, 16'h0999, 16'h0, 16'h0, 1'b0);
      issue(1'b1, 2, 16'h0888, 16'h0, 16'h0, 1'b0);
      // BEZ taken, BNEZ on zero not taken, BNEZ on nonzero taken.
      issue(1'b1, 2, 16'h0050, 16'h0, 16'h0000, 1'b0);
      idle(2);
      issue(1'b1, 3, 16'h0060, 16'h0, 16'h0000, 1'b0);
      issue(1'b1, 3, 16'h0070, 16'h0, 16'h0003, 1'b0);
      idle(2);
      issue(1'b1, 4, 16'h0080, 16'h0, 16'h0001, 1'b0);
      issue(1'b1, 7, 16'h0090, 16'h0, 16'h0000, 1'b0);
      // Nested CALL/RET.
      issue(1'b1, 5, 16'h0100, 16'h0011, 16'h1, 1'b0); idle(2);
      issue(1'b1, 5, 16'h0200, 16'h0101, 16'h1, 1'b0); idle(2);
      issue(1'b1, 6, 16'h0000, 16'h0, 16'h1, 1'b0); idle(2);
      issue(1'b1, 6, 16'h0000, 16'h0, 16'h1, 1'b0); idle(2);
      // Overflow with five CALLs, drain with four RETs, then underflow.
      for (int i = 1; i <= 5; i++) begin
         issue(1'b1, 5, 16'h0300 + 16'(i), 16'(i), 16'h1, 1'b0); idle(2);
      end
      for (int i = 0; i < 5; i++) begin
         issue(1'b1, 6, 16'h0000, 16'h0, 16'h1, 1'b0); idle(2);
      end
      // err_clr alone clears; err_clr with a new underflow keeps the flag.
      issue(1'b0, 0, 16'h0, 16'h0, 16'h1, 1'b1);
      issue(1'b1, 6, 16'h0000, 16'h0, 16'h1, 1'b1);
      issue(1'b0, 0, 16'h0, 16'h0, 16'h1, 1'b1);

      // Asynchronous reset in the middle of a flush window with two entries.
      issue(1'b1, 5, 16'h0400, 16'h0A01, 16'h1, 1'b0); idle(2);
      issue(1'b1, 5, 16'h0500, 16'h0A02, 16'h1, 1'b0);
      @(posedge clk);
      #3;
      chk("pre_rst_flush", 32'(flush), 1);
      chk("pre_rst_count", 32'(stack_count), 2);
      rst = 1'b1;
      #1;
      chk("async_flush", 32'(flush), 0);
      chk("async_count", 32'(stack_count), 0);
      chk("async_jump_flag", 32'(jump_flag), 0);
      chk("async_jump_addr", 32'(jump_addr), 0);
      valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      issue(1'b1, 6, 16'h0000, 16'h0, 16'h1, 1'b0);
      idle(1);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         issue(($urandom % 4) != 0, int'($urandom % 8), 16'($urandom), 16'($urandom),
               (($urandom % 2) != 0) ? 16'h0 : 16'($urandom), ($urandom % 16) == 0);
      end
      idle(3);

      for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
      #3;
      chk("scoreboard_drained", 32'(sb.size()), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dsp_branch_ctrl.md
# dsp_branch_ctrl

Registered, parametrised branch controller for the DSP core; the next generation of the combinational branch resolver. Sits between execute (ALU result, decoded flow mode, target address) and fetch (redirect). Adds over the previous generation:
- correct BNEZ semantics;
- CALL/RET via an internal return-address stack;
- a pipeline flush window after every taken redirect;
- sticky stack-error flags.

## Interface
Parameters:
- ADDR_W, 16, instruction address width
- DATA_W, 16, ALU result width
- STACK_DEPTH, 4, return-stack entries; power of two, >= 2
- FLUSH_CYCLES, 2, cycles `flush` stays high after a taken redirect; >= 1

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- valid  in  1  execute-stage instruction is valid this cycle
- flow_mode  in  FLOW_MODE_LEN (3)  decoded flow code
- address  in  ADDR_W  branch/jump/call target
- return_addr  in  ADDR_W  address of the instruction following the branch
- alu_result  in  DATA_W  condition operand (BEQ: ALU computes a-b)
- err_clr  in  1  synchronous clear of the sticky error flags
- jump_addr  out  ADDR_W  redirect target to fetch
- jump_flag  out  1  one-cycle redirect pulse to fetch
- flush  out  1  squash younger in-flight instructions
- stack_count  out  $clog2(STACK_DEPTH)+1  current stack occupancy
- stack_overflow  out  1  sticky; a CALL was issued with the stack full
- stack_underflow  out  1  sticky; a RET was issued with the stack empty

## Operation
- Flow codes: NONE=0, JMP=1, BEZ=2, BNEZ=3, BEQ=4, CALL=5, RET=6, 7 reserved (treated as NONE).
- Accepted instruction: `valid`=1 and `flush`=0. Anything arriving while `flush`=1 is squashed: no state change, no redirect.
- Taken conditions:
  - JMP, CALL: always taken.
  - BEZ, BEQ: taken when alu_result == 0.
  - BNEZ: taken when alu_result != 0.
  - RET: taken when stack_count != 0.
- Redirect target: `address` for every taken mode except RET. RET redirects to the popped top of stack.
- CALL pushes `return_addr`.
  - When the stack is full, the push overwrites the oldest entry (circular buffer).
  - stack_count saturates at STACK_DEPTH.
  - stack_overflow is set.
  - The jump is still taken.
- RET on an empty stack: no jump; stack_underflow is set; stack_count stays 0.
- Sticky flags clear only on rst or err_clr=1. If a set event and err_clr occur in the same cycle, the set wins.
- Flush counter:
  - Loaded with FLUSH_CYCLES on any taken redirect.
  - `flush` = counter != 0.
  - Decrements each cycle until it reaches 0.
- When the branch is not taken, jump_addr holds its previous value.

## Timing
- Reset values: jump_addr=0, jump_flag=0, flush=0, stack_count=0, stack_overflow=0, stack_underflow=0. Stack contents are cleared to 0.
- Latency: an instruction accepted at edge N produces jump_flag=1 and a valid jump_addr in cycle N+1, for exactly one cycle.
- flush rises in the same cycle as jump_flag and stays high for FLUSH_CYCLES cycles. A new accept is possible in the first cycle with flush=0.
- Push/pop take effect on the accepting edge; stack_count updates in cycle N+1.
- Back-to-back taken branches cannot occur, because the flush window squashes the second one.
- Back-to-back not-taken instructions are accepted every cycle.
- rst mid-flush: counter cleared and stack emptied immediately (asynchronous). jump_flag drops to 0 without completing the pulse.

## Structure
- Shared definitions include: FLOW_MODE_LEN and the FLOW_NONE…FLOW_RET codes (FLOW_BEQ and FLOW_CALL/FLOW_RET added/renumbered to match the codes above). Decode and this block use the same include.
- Sub-module dsp_ret_stack, parametrised by ADDR_W and STACK_DEPTH:
  - inputs: push, pop, din;
  - outputs: dout (top), count, full, empty;
  - wrapping pointer; overwrite on full.
- Flush counter and condition evaluation live in the top module.

## Test plan
- JMP to 0x0040 accepted at cycle 5 -> cycle 6: jump_flag=1, jump_addr=0x0040; flush=1 in cycles 6–7 (FLUSH_CYCLES=2); valid instructions in cycles 6–7 produce no redirect.
- BEZ with alu_result=0x0000, then (after flush) BNEZ with alu_result=0x0000 -> first is taken, second is not taken (jump_flag stays 0); BNEZ with alu_result=0x0003 -> taken.
- CALL 0x0100 with return_addr=0x0011, then CALL 0x0200 with return_addr=0x0101, then RET, RET -> redirects to 0x0100, 0x0200, 0x0101, 0x0011; stack_count goes 1, 2, 1, 0.
- Five CALLs (return_addr 1..5, STACK_DEPTH=4) then four RETs -> stack_overflow=1, stack_count=4, RETs return 5, 4, 3, 2; a fifth RET gives no jump and stack_underflow=1.
- err_clr pulsed while stack_underflow=1 -> flag reads 0 next cycle; RET on an empty stack in the same cycle as err_clr -> flag stays 1.
- rst asserted asynchronously mid-flush with 2 stack entries -> flush=0, stack_count=0, jump_flag=0 immediately; a RET after reset is not taken.
